// File: rtl/light_hash_pkg.sv
// Shared definitions for the light-hash datapath: IV, null character,
// sequencer state encoding and the AES-128 S-box lookup.
package light_hash_pkg;

  localparam int LH_NUM_BYTES = 8;

  localparam logic [7:0] LH_NULL_CHAR = 8'h00;

  // Initial chaining value, index 0..7
  localparam logic [7:0] LH_IV [LH_NUM_BYTES] = '{
    8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC0, 8'h2B, 8'hEE
  };

  typedef enum logic [1:0] {
    LH_IDLE   = 2'd0,
    LH_ABSORB = 2'd1,
    LH_OUTPUT = 2'd2
  } lh_state_t;

  localparam logic [7:0] LH_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward AES S-box, shared with the unrolled hash datapath
  function automatic logic [7:0] aes128_sbox(input logic [7:0] x);
    return LH_SBOX[x];
  endfunction

endpackage

// File: rtl/light_hash_step.sv
// One absorb step: mix the source byte with the character, shift left by the
// step index (dropping bits above bit 7), then substitute through the S-box.
module light_hash_step
  import light_hash_pkg::*;
(
  input  logic [7:0] src_byte,
  input  logic [7:0] char_byte,
  input  logic [2:0] step_idx,
  output logic [7:0] new_byte
);

  logic [7:0] mixed_s;

  // Mix, truncate-shift and substitute
  always_comb begin
    mixed_s  = (src_byte ^ char_byte) << step_idx;
    new_byte = aes128_sbox(mixed_s);
  end

endmodule

// File: rtl/light_hash_seq.sv
// Light-hash sequencer: accepts a framed plaintext byte stream, runs the
// in-place absorb schedule (NUM_ROUNDS rounds x 8 steps per character) on a
// single shared S-box, then streams the 8-byte digest out byte 0 first.
module light_hash_seq
  import light_hash_pkg::*;
#(
  parameter int NUM_ROUNDS   = 32,
  parameter int DIGEST_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ptxt_char,
  input  logic       ptxt_valid,
  input  logic       ptxt_last,
  output logic       ptxt_ready,
  output logic [7:0] digest_char,
  output logic       digest_valid,
  input  logic       digest_ack,
  output logic       err_invalid_ptxt_char
);

  localparam int             RW         = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [RW-1:0]  LAST_ROUND = RW'(NUM_ROUNDS - 1);
  localparam logic [2:0]     LAST_OUT   = 3'(DIGEST_BYTES - 1);

  lh_state_t      state_r;
  logic [7:0]     d_r [LH_NUM_BYTES];
  logic [7:0]     char_r;
  logic           last_r;
  logic [2:0]     step_r;
  logic [RW-1:0]  round_r;
  logic [2:0]     out_idx_r;
  logic           ready_r;
  logic           dvalid_r;
  logic [7:0]     dchar_r;
  logic           err_r;

  logic           accept_s;
  logic           null_s;
  logic           absorb_done_s;
  logic [7:0]     src_s;
  logic [7:0]     new_s;

  // Handshake decode and the in-place source byte d[(step+2) mod 8]
  always_comb begin
    accept_s      = ptxt_valid & ready_r;
    null_s        = (ptxt_char == LH_NULL_CHAR);
    absorb_done_s = (step_r == 3'd7) && (round_r == LAST_ROUND);
    src_s         = d_r[step_r + 3'd2];
  end

  light_hash_step u_step (
    .src_byte  (src_s),
    .char_byte (char_r),
    .step_idx  (step_r),
    .new_byte  (new_s)
  );

  // Sequencer FSM, state register, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= LH_IDLE;
      for (int k = 0; k < LH_NUM_BYTES; k++) begin
        d_r[k] <= LH_IV[k];
      end
      char_r    <= 8'h00;
      last_r    <= 1'b0;
      step_r    <= 3'd0;
      round_r   <= '0;
      out_idx_r <= 3'd0;
      ready_r   <= 1'b1;
      dvalid_r  <= 1'b0;
      dchar_r   <= 8'h00;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        LH_IDLE: begin
          if (accept_s) begin
            if (null_s) begin
              // Null byte is dropped; ptxt_last on this beat does not end the message
              err_r <= 1'b1;
            end else begin
              char_r  <= ptxt_char;
              last_r  <= ptxt_last;
              step_r  <= 3'd0;
              round_r <= '0;
              ready_r <= 1'b0;
              state_r <= LH_ABSORB;
            end
          end
        end

        LH_ABSORB: begin
          d_r[step_r] <= new_s;
          step_r      <= step_r + 3'd1;
          if (step_r == 3'd7) begin
            round_r <= round_r + RW'(1);
          end
          if (absorb_done_s) begin
            if (last_r) begin
              // Step 7 writes d[7] only, so d[0] is already final here
              state_r   <= LH_OUTPUT;
              dvalid_r  <= 1'b1;
              dchar_r   <= d_r[0];
              out_idx_r <= 3'd0;
            end else begin
              state_r <= LH_IDLE;
              ready_r <= 1'b1;
            end
          end
        end

        LH_OUTPUT: begin
          if (digest_ack) begin
            if (out_idx_r == LAST_OUT) begin
              for (int k = 0; k < LH_NUM_BYTES; k++) begin
                d_r[k] <= LH_IV[k];
              end
              dvalid_r  <= 1'b0;
              dchar_r   <= 8'h00;
              out_idx_r <= 3'd0;
              ready_r   <= 1'b1;
              state_r   <= LH_IDLE;
            end else begin
              out_idx_r <= out_idx_r + 3'd1;
              dchar_r   <= d_r[out_idx_r + 3'd1];
            end
          end
        end

        default: begin
          state_r  <= LH_IDLE;
          ready_r  <= 1'b1;
          dvalid_r <= 1'b0;
          dchar_r  <= 8'h00;
        end
      endcase
    end
  end

  assign ptxt_ready            = ready_r;
  assign digest_valid          = dvalid_r;
  assign digest_char           = dchar_r;
  assign err_invalid_ptxt_char = err_r;

endmodule

// File: tb/tb_light_hash_seq.sv
// Self-checking bench for light_hash_seq: an independent golden model of the
// in-place absorb schedule (S-box derived from GF(2^8) inversion) feeds a
// scoreboard of expected digest bytes that is drained as the DUT emits them.
module tb_light_hash_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ptxt_char;
  logic       ptxt_valid;
  logic       ptxt_last;
  logic       ptxt_ready;
  logic [7:0] digest_char;
  logic       digest_valid;
  logic       digest_ack;
  logic       err_invalid_ptxt_char;

  light_hash_seq #(.NUM_ROUNDS(32), .DIGEST_BYTES(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ptxt_char             (ptxt_char),
    .ptxt_valid            (ptxt_valid),
    .ptxt_last             (ptxt_last),
    .ptxt_ready            (ptxt_ready),
    .digest_char           (digest_char),
    .digest_valid          (digest_valid),
    .digest_ack            (digest_ack),
    .err_invalid_ptxt_char (err_invalid_ptxt_char)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int err_seen      = 0;
  int cyc           = 0;

  logic [7:0] ref_tab [256];
  logic [7:0] md [8];
  logic [7:0] sb_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (err_invalid_ptxt_char === 1'b1) err_seen <= err_seen + 1;
  end

  // ---------------- golden model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = (a << 1) ^ 8'h1b;
      else      a = a << 1;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] r, p, s;
    int e;
    r = 8'h01; p = x; e = 254;
    while (e > 0) begin
      if (e % 2 == 1) r = gf_mul(r, p);
      p = gf_mul(p, p);
      e = e / 2;
    end
    if (x == 8'h00) r = 8'h00;
    s = r ^ ((r << 1) | (r >> 7)) ^ ((r << 2) | (r >> 6))
          ^ ((r << 3) | (r >> 5)) ^ ((r << 4) | (r >> 4)) ^ 8'h63;
    return s;
  endfunction

  task automatic model_reset();
    md[0] = 8'h34; md[1] = 8'h55; md[2] = 8'h0F; md[3] = 8'h14;
    md[4] = 8'hDA; md[5] = 8'hC0; md[6] = 8'h2B; md[7] = 8'hEE;
  endtask

  task automatic model_absorb(input logic [7:0] c);
    logic [7:0] t;
    for (int r = 0; r < 32; r++) begin
      for (int i = 0; i < 8; i++) begin
        t = (md[(i + 2) % 8] ^ c) << i;
        md[i] = ref_tab[t];
      end
    end
  endtask

  task automatic model_push();
    for (int i = 0; i < 8; i++) sb_q.push_back(md[i]);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] c, input logic last, output int acc_cyc);
    int n;
    @(negedge clk);
    ptxt_valid = 1'b1; ptxt_char = c; ptxt_last = last;
    n = 0;
    while (ptxt_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks_total++;
    if (ptxt_ready !== 1'b1) $display("FAIL accept_wait: ptxt_ready=%b required 1 within 1000 cycles", ptxt_ready);
    else checks_passed++;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    ptxt_valid = 1'b0;
    if (c != 8'h00) begin
      model_absorb(c);
      if (last) begin
        model_push();
        model_reset();
      end
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (ptxt_ready === 1'b0 && digest_valid === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic receive_digest(input int hold_idx, input int hold_cycles);
    int n;
    logic [7:0] exp;
    n = 0;
    while (digest_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks_total++;
    if (digest_valid !== 1'b1) $display("FAIL digest_wait: digest_valid=%b required 1 within 1000 cycles", digest_valid);
    else checks_passed++;
    for (int k = 0; k < 8; k++) begin
      exp = 8'hxx;
      if (sb_q.size() > 0) exp = sb_q.pop_front();
      if (k == hold_idx) begin
        digest_ack = 1'b0;
        for (int h = 0; h < hold_cycles; h++) begin
          @(negedge clk);
          checks_total++;
          if (digest_valid !== 1'b1 || digest_char !== exp)
            $display("FAIL digest_hold[%0d]: valid=%b char=%h required valid=1 char=%h", h, digest_valid, digest_char, exp);
          else checks_passed++;
        end
      end
      checks_total++;
      if (digest_valid !== 1'b1 || digest_char !== exp)
        $display("FAIL digest_byte[%0d]: valid=%b char=%h required valid=1 char=%h", k, digest_valid, digest_char, exp);
      else checks_passed++;
      digest_ack = 1'b1;
      @(negedge clk);
    end
    digest_ack = 1'b0;
    checks_total++;
    if (ptxt_ready !== 1'b1 || digest_valid !== 1'b0)
      $display("FAIL post_digest: ready=%b valid=%b required ready=1 valid=0", ptxt_ready, digest_valid);
    else checks_passed++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ptxt_valid = 1'b0; ptxt_char = 8'h00; ptxt_last = 1'b0; digest_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks_total++;
    if (ptxt_ready !== 1'b1 || digest_valid !== 1'b0 || digest_char !== 8'h00 || err_invalid_ptxt_char !== 1'b0)
      $display("FAIL reset_outputs: ready=%b valid=%b char=%h err=%b required 1 0 00 0",
               ptxt_ready, digest_valid, digest_char, err_invalid_ptxt_char);
    else checks_passed++;
  endtask

  task automatic test_single();
    int a, n;
    digest_ack = 1'b1;
    send_byte(8'h61, 1'b1, a);
    count_busy(n);
    checks_total++;
    if (n !== 256) $display("FAIL busy_cycles: got %0d required 256", n);
    else checks_passed++;
    receive_digest(-1, 0);
  endtask

  task automatic test_abc();
    int a0, a1, a2;
    for (int rep = 0; rep < 2; rep++) begin
      send_byte(8'h61, 1'b0, a0);
      send_byte(8'h62, 1'b0, a1);
      send_byte(8'h63, 1'b1, a2);
      checks_total++;
      if (a1 - a0 !== 257 || a2 - a1 !== 257)
        $display("FAIL abc_spacing: got %0d,%0d required 257,257", a1 - a0, a2 - a1);
      else checks_passed++;
      receive_digest(-1, 0);
    end
  endtask

  task automatic test_null();
    int a;
    send_byte(8'h00, 1'b1, a);
    @(negedge clk);
    checks_total++;
    if (err_invalid_ptxt_char !== 1'b1 || ptxt_ready !== 1'b1)
      $display("FAIL null_err: err=%b ready=%b required err=1 ready=1", err_invalid_ptxt_char, ptxt_ready);
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (err_invalid_ptxt_char !== 1'b0 || digest_valid !== 1'b0)
      $display("FAIL null_pulse: err=%b valid=%b required err=0 valid=0", err_invalid_ptxt_char, digest_valid);
    else checks_passed++;
    send_byte(8'h61, 1'b1, a);
    receive_digest(-1, 0);
  endtask

  task automatic test_backpressure();
    int a;
    send_byte(8'h7a, 1'b1, a);
    receive_digest(3, 5);
  endtask

  task automatic test_reset_abort();
    int a, n;
    // abort mid-absorb
    send_byte(8'h61, 1'b1, a);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks_total++;
    if (ptxt_ready !== 1'b1 || digest_valid !== 1'b0)
      $display("FAIL async_rst_absorb: ready=%b valid=%b required 1 0", ptxt_ready, digest_valid);
    else checks_passed++;
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    // abort while digest is being presented
    send_byte(8'h33, 1'b1, a);
    n = 0;
    while (digest_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    checks_total++;
    if (ptxt_ready !== 1'b1 || digest_valid !== 1'b0 || digest_char !== 8'h00)
      $display("FAIL async_rst_output: ready=%b valid=%b char=%h required 1 0 00", ptxt_ready, digest_valid, digest_char);
    else checks_passed++;
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h61, 1'b1, a);
    receive_digest(-1, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_tab[i] = calc_sbox(8'(i));
    test_reset();
    test_single();
    test_abc();
    test_null();
    test_backpressure();
    test_reset_abort();
    checks_total++;
    if (sb_q.size() !== 0) $display("FAIL scoreboard_empty: %0d left required 0", sb_q.size());
    else checks_passed++;
    checks_total++;
    if (err_seen !== 1) $display("FAIL err_pulse_count: got %0d required 1", err_seen);
    else checks_passed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
